// File: rtl/sram_pkg.sv
// Shared definitions for the SRAM responder: FSM state encoding, default
// geometry/latency constants and the parity helper used by the optional
// parity-protected array (SRAM_RESP_PARITY_EN).
package sram_pkg;

  localparam int DW_DEF       = 8;
  localparam int AW_DEF       = 4;
  localparam int READ_LAT_DEF = 2;

  // Widest word the parity helper accepts; callers zero-extend into it.
  localparam int PAR_MAX_W    = 64;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITE     = 2'd1,
    READ_WAIT = 2'd2,
    DRIVE     = 2'd3
  } state_e;

  // Even parity bit: makes the total count of ones (data + bit) even.
  // Zero-extension does not change the XOR reduction.
  function automatic logic even_parity(input logic [PAR_MAX_W-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/sram_edge_sync.sv
// Registers the six SRAM control inputs once and derives the edge pulses the
// responder FSM needs by comparing each registered value with its previous
// registered value. Active-low strobes reset to their inactive (high) level.
module sram_edge_sync (
  input  logic clk,
  input  logic reset,
  input  logic count,
  input  logic latch,
  input  logic de,
  input  logic n_ce,
  input  logic n_oe,
  input  logic n_we,
  output logic count_rise,
  output logic latch_lvl,
  output logic de_lvl,
  output logic n_ce_lvl,
  output logic n_oe_lvl,
  output logic n_we_lvl,
  output logic n_we_rise,
  output logic n_we_fall
);

  // Bit order: {n_we, n_oe, n_ce, de, latch, count}
  localparam logic [5:0] SYNC_RST = 6'b111000;

  logic [5:0] sync_q, sync_d;
  logic       count_prev_q, count_prev_d;
  logic       n_we_prev_q, n_we_prev_d;

  // Next values: sample raw inputs, and keep the prior registered copy for edges.
  always_comb begin
    sync_d       = {n_we, n_oe, n_ce, de, latch, count};
    count_prev_d = sync_q[0];
    n_we_prev_d  = sync_q[5];
  end

  // Input register and previous-value register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q       <= SYNC_RST;
      count_prev_q <= 1'b0;
      n_we_prev_q  <= 1'b1;
    end else begin
      sync_q       <= sync_d;
      count_prev_q <= count_prev_d;
      n_we_prev_q  <= n_we_prev_d;
    end
  end

  assign count_rise = sync_q[0] & ~count_prev_q;
  assign latch_lvl  = sync_q[1];
  assign de_lvl     = sync_q[2];
  assign n_ce_lvl   = sync_q[3];
  assign n_oe_lvl   = sync_q[4];
  assign n_we_lvl   = sync_q[5];
  assign n_we_rise  = sync_q[5] & ~n_we_prev_q;
  assign n_we_fall  = ~sync_q[5] & n_we_prev_q;

endmodule

// File: rtl/sram_responder.sv
// Memory-side responder for the SRAM read/write cycle controllers: address
// counter, write-data hold register, synchronous storage array and a small
// FSM that commits writes on n_we rising and returns reads after READ_LAT
// cycles. Protocol violations raise a sticky err flag.
// Optional feature macro: SRAM_RESP_PARITY_EN adds a parity bit per word,
// a sticky parity error folded into err and the par_err port.
module sram_responder
  import sram_pkg::*;
#(
  parameter int DW       = DW_DEF,
  parameter int AW       = AW_DEF,
  parameter int READ_LAT = READ_LAT_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          count,
  input  logic          latch,
  input  logic          de,
  input  logic          n_ce,
  input  logic          n_oe,
  input  logic          n_we,
  input  logic [DW-1:0] data_in,
  output logic [DW-1:0] data_out,
  output logic          data_valid,
  output logic [AW-1:0] addr,
  output logic          busy,
  output logic          err
`ifdef SRAM_RESP_PARITY_EN
  ,
  output logic          par_err
`endif
);

`ifdef SRAM_RESP_PARITY_EN
  localparam int MW = DW + 1;
`else
  localparam int MW = DW;
`endif
  localparam int CW    = 3;
  localparam int DEPTH = 2 ** AW;

  logic count_rise, latch_lvl, de_lvl, n_ce_lvl, n_oe_lvl, n_we_lvl;
  logic n_we_rise, n_we_fall;

  state_e        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] hold_q, hold_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] dout_q, dout_d;
  logic          dv_q, dv_d;
  logic          err_q, err_d;
  logic          busy_q, busy_d;

  logic [MW-1:0] mem_q [DEPTH];
  logic [MW-1:0] rd_word;
  logic [MW-1:0] wr_word;
  logic          mem_we;
  logic          load;
  logic          viol;

  sram_edge_sync u_edge_sync (
    .clk        (clk),
    .reset      (reset),
    .count      (count),
    .latch      (latch),
    .de         (de),
    .n_ce       (n_ce),
    .n_oe       (n_oe),
    .n_we       (n_we),
    .count_rise (count_rise),
    .latch_lvl  (latch_lvl),
    .de_lvl     (de_lvl),
    .n_ce_lvl   (n_ce_lvl),
    .n_oe_lvl   (n_oe_lvl),
    .n_we_lvl   (n_we_lvl),
    .n_we_rise  (n_we_rise),
    .n_we_fall  (n_we_fall)
  );

  assign rd_word = mem_q[addr_q];

`ifdef SRAM_RESP_PARITY_EN
  logic par_err_q, par_err_d;

  assign wr_word = {even_parity(PAR_MAX_W'(hold_q)), hold_q};

  // Sticky parity flag: checked every time data_out is (re)loaded.
  always_comb begin
    par_err_d = par_err_q;
    if (load && (even_parity(PAR_MAX_W'(rd_word[DW-1:0])) != rd_word[DW])) begin
      par_err_d = 1'b1;
    end
  end

  // Parity flag register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) par_err_q <= 1'b0;
    else        par_err_q <= par_err_d;
  end

  assign par_err = par_err_q;
  assign err     = err_q | par_err_q;
`else
  assign wr_word = hold_q;
  assign err     = err_q;
`endif

  // Next-state logic: address counter, hold register, FSM and read path.
  // A write commits at addr_q, i.e. before any same-cycle count increment.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q + AW'(count_rise);
    hold_d  = latch_lvl ? data_in : hold_q;
    cnt_d   = cnt_q;
    dout_d  = dout_q;
    dv_d    = dv_q;
    err_d   = err_q;
    mem_we  = 1'b0;
    load    = 1'b0;

    viol = (!n_ce_lvl && !n_oe_lvl && !n_we_lvl) ||
           (n_we_fall && ((state_q == READ_WAIT) || (state_q == DRIVE)));

    if (viol) begin
      err_d   = 1'b1;
      dv_d    = 1'b0;
      state_d = IDLE;
    end else if (n_ce_lvl) begin
      dv_d    = 1'b0;
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (!n_we_lvl) begin
            state_d = WRITE;
          end else if (!n_oe_lvl) begin
            // With a one-cycle latency there is no wait phase at all.
            if (READ_LAT == 1) begin
              load    = 1'b1;
              state_d = DRIVE;
            end else begin
              cnt_d   = CW'(READ_LAT - 1);
              state_d = READ_WAIT;
            end
          end
        end
        WRITE: begin
          if (n_we_rise) begin
            mem_we  = de_lvl;
            state_d = IDLE;
          end
        end
        READ_WAIT: begin
          if (n_oe_lvl) begin
            dv_d    = 1'b0;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q - CW'(1);
            if (cnt_d == '0) begin
              load    = 1'b1;
              state_d = DRIVE;
            end
          end
        end
        DRIVE: begin
          if (n_oe_lvl) begin
            dv_d    = 1'b0;
            state_d = IDLE;
          end else begin
            load = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    if (load) begin
      dout_d = rd_word[DW-1:0];
      dv_d   = 1'b1;
    end

    busy_d = (state_d != IDLE);
  end

  // FSM state and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      hold_q  <= '0;
      cnt_q   <= '0;
      dout_q  <= '0;
      dv_q    <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      hold_q  <= hold_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      dv_q    <= dv_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

  // Storage array: contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[addr_q] <= wr_word;
  end

  assign data_out   = dout_q;
  assign data_valid = dv_q;
  assign addr       = addr_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_sram_responder.sv
// Directed testbench for sram_responder: reset state, gated and committed
// writes, read latency, burst wrap, reset mid-burst, chip-enable abort,
// protocol violation and (with SRAM_RESP_PARITY_EN) parity error detection.
module tb_sram_responder;

  localparam int DW = 8;
  localparam int AW = 4;
  localparam int RL = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          count = 1'b0;
  logic          latch = 1'b0;
  logic          de = 1'b0;
  logic          n_ce = 1'b0;
  logic          n_oe = 1'b1;
  logic          n_we = 1'b1;
  logic [DW-1:0] data_in = '0;
  logic [DW-1:0] data_out;
  logic          data_valid;
  logic [AW-1:0] addr;
  logic          busy;
  logic          err;
`ifdef SRAM_RESP_PARITY_EN
  logic          par_err;
`endif

  int n_checks = 0;
  int n_errors = 0;

  sram_responder #(.DW(DW), .AW(AW), .READ_LAT(RL)) dut (
    .clk        (clk),
    .reset      (reset),
    .count      (count),
    .latch      (latch),
    .de         (de),
    .n_ce       (n_ce),
    .n_oe       (n_oe),
    .n_we       (n_we),
    .data_in    (data_in),
    .data_out   (data_out),
    .data_valid (data_valid),
    .addr       (addr),
    .busy       (busy),
    .err        (err)
`ifdef SRAM_RESP_PARITY_EN
    ,
    .par_err    (par_err)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_count();
    count = 1'b1;
    tick();
    count = 1'b0;
    tick();
  endtask

  task automatic goto_addr(input int a);
    for (int i = 0; i < 2 ** AW && addr != AW'(a); i++) pulse_count();
    chk("addr_seek", 32'(addr), 32'(a));
  endtask

  task automatic do_write(input logic [DW-1:0] d, input logic en);
    data_in = d;
    latch   = 1'b1;
    tick(2);
    latch = 1'b0;
    de    = en;
    n_we  = 1'b0;
    tick(2);
    n_we = 1'b1;
    tick(3);
    de = 1'b0;
  endtask

  task automatic do_read(input string tag, input logic [DW-1:0] exp);
    n_oe = 1'b0;
    tick(RL);
    chk({tag, "_early"}, 32'(data_valid), 32'd0);
    tick();
    chk({tag, "_dv"}, 32'(data_valid), 32'd1);
    chk({tag, "_data"}, 32'(data_out), 32'(exp));
    n_oe = 1'b1;
    tick(3);
    chk({tag, "_dv_clr"}, 32'(data_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    tick(2);
    chk("rst_addr", 32'(addr), 32'd0);
    chk("rst_dout", 32'(data_out), 32'd0);
    chk("rst_dv", 32'(data_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    reset = 1'b1;
    tick(2);

    // Gated write leaves old contents
    goto_addr(3);
    do_write(8'h00, 1'b1);
    do_write(8'h5A, 1'b0);
    chk("gated_err", 32'(err), 32'd0);
    do_read("gated", 8'h00);

    // Write / read-back with latency check
    do_write(8'hA5, 1'b1);
    do_read("wr_rd", 8'hA5);
    chk("wr_rd_addr", 32'(addr), 32'd3);
    chk("wr_rd_err", 32'(err), 32'd0);

    // Burst wrap: fill 0x10..0x1F, then read from 15 across the wrap
    goto_addr(0);
    for (int i = 0; i < 2 ** AW; i++) begin
      do_write(8'(16 + i), 1'b1);
      pulse_count();
    end
    chk("fill_wrap_addr", 32'(addr), 32'd0);
    goto_addr(15);
    n_oe = 1'b0;
    tick(RL + 1);
    chk("burst_dv", 32'(data_valid), 32'd1);
    chk("burst_d15", 32'(data_out), 32'h1F);
    chk("burst_busy", 32'(busy), 32'd1);
    count = 1'b1;
    tick();
    count = 1'b0;
    tick();
    chk("burst_addr0", 32'(addr), 32'd0);
    chk("burst_d15_hold", 32'(data_out), 32'h1F);
    tick();
    chk("burst_d0", 32'(data_out), 32'h10);
    chk("burst_dv2", 32'(data_valid), 32'd1);
    n_oe = 1'b1;
    tick(3);
    chk("burst_end_busy", 32'(busy), 32'd0);

    // Chip-enable high aborts a read in progress
    n_oe = 1'b0;
    tick(RL + 1);
    chk("ce_abort_pre", 32'(data_valid), 32'd1);
    n_ce = 1'b1;
    tick(2);
    chk("ce_abort_dv", 32'(data_valid), 32'd0);
    chk("ce_abort_busy", 32'(busy), 32'd0);
    n_oe = 1'b1;
    n_ce = 1'b0;
    tick(2);

    // Asynchronous reset in the middle of a burst at addr 5
    goto_addr(5);
    n_oe = 1'b0;
    tick(RL + 1);
    chk("mid_dv", 32'(data_valid), 32'd1);
    chk("mid_data", 32'(data_out), 32'h15);
    #2;
    reset = 1'b0;
    #1;
    chk("async_addr", 32'(addr), 32'd0);
    chk("async_dv", 32'(data_valid), 32'd0);
    chk("async_err", 32'(err), 32'd0);
    chk("async_busy", 32'(busy), 32'd0);
    n_oe = 1'b1;
    tick(2);
    reset = 1'b1;
    tick(2);
    goto_addr(5);
    do_read("rst_keep", 8'h15);

    // Protocol violation: n_oe and n_we low together while selected
    n_oe = 1'b0;
    n_we = 1'b0;
    tick(2);
    chk("viol_err", 32'(err), 32'd1);
    chk("viol_busy", 32'(busy), 32'd0);
    n_oe = 1'b1;
    n_we = 1'b1;
    tick(3);
    chk("viol_sticky", 32'(err), 32'd1);
    do_read("viol_keep", 8'h15);
    chk("viol_sticky2", 32'(err), 32'd1);
    reset = 1'b0;
    #1;
    chk("viol_clr", 32'(err), 32'd0);
    tick();
    reset = 1'b1;
    tick(2);

`ifdef SRAM_RESP_PARITY_EN
    // Corrupted stored bit is caught when the word is loaded
    goto_addr(2);
    do_write(8'h3C, 1'b1);
    chk("par_pre", 32'(par_err), 32'd0);
    dut.mem_q[2] = dut.mem_q[2] ^ 9'h001;
    n_oe = 1'b0;
    tick(RL);
    chk("par_early", 32'(par_err), 32'd0);
    tick();
    chk("par_dv", 32'(data_valid), 32'd1);
    chk("par_flag", 32'(par_err), 32'd1);
    chk("par_err", 32'(err), 32'd1);
    n_oe = 1'b1;
    tick(3);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/sram_responder.md
Name: sram_responder

Overview:
- Memory-side end of the SRAM control interface produced by the lab's read/write cycle controllers.
- Consumes count, latch, de, n_ce, n_oe and n_we. Keeps an internal address counter and a synchronous storage array.
- Commits writes and returns read data with a fixed latency.
- Used as the device model and loopback target for the controller top, and is synthesizable for on-board loopback.

Parameters:
- DW, 8, data word width in bits
- AW, 4, address width; array depth is 2**AW words
- READ_LAT, 2, cycles from read start (n_oe falling while selected) to data valid; legal range 1..7

Ports:
- clk  input  1  single system clock; all state updates on its rising edge
- reset  input  1  asynchronous, active-low reset
- count  input  1  address-advance strobe; a rising edge increments the address
- latch  input  1  write-data capture strobe; level-sensitive sample of data_in
- de  input  1  data enable; a write commits only while de=1
- n_ce  input  1  chip enable, active low
- n_oe  input  1  output enable, active low
- n_we  input  1  write enable, active low; the write commits on its rising edge
- data_in  input  DW  write data from the controller
- data_out  output  DW  read data
- data_valid  output  1  data_out holds valid read data
- addr  output  AW  current address counter value
- busy  output  1  state is not IDLE
- err  output  1  sticky protocol-violation flag

Behaviour:
- Reset (reset=0, asynchronous) sets: addr=0, data_out=0, data_valid=0, busy=0, err=0, hold register=0, state=IDLE. Array contents are not cleared.
- All control inputs are registered once. Edge detection compares the registered value with the previous registered value. All latencies below count from the registered edge.
- Address counter:
  - Increments by 1 on each registered rising edge of count, in any state.
  - Wraps from 2**AW-1 to 0 with no flag.
- Hold register: loads data_in on every cycle where registered latch=1.
- IDLE:
  - n_ce=0 and n_we=0 go to WRITE.
  - Otherwise n_ce=0 and n_oe=0 go to READ_WAIT, with the latency counter loaded to READ_LAT-1.
- WRITE:
  - On the n_we rising edge, if de=1, write the hold register to array[addr], then go to IDLE.
  - If de=0 at that edge, no write occurs; go to IDLE.
  - If n_ce rises before n_we rises, abort with no write; go to IDLE.
- READ_WAIT:
  - Decrement the latency counter each cycle.
  - When it reaches 0, load data_out from array[addr], set data_valid=1 and go to DRIVE.
  - If n_oe or n_ce rises first, abort to IDLE with data_valid=0.
  - Net latency: data_valid rises READ_LAT cycles after the registered n_oe fall.
- DRIVE:
  - data_out tracks array[addr] every cycle, so a count edge during a burst returns the next word one cycle later.
  - n_oe=1 or n_ce=1 clears data_valid (data_out holds its last value) and returns to IDLE.
- Violations set err=1; err is cleared only by reset:
  - n_oe=0 and n_we=0 together while n_ce=0.
  - n_we falling while in READ_WAIT or DRIVE.
  - On a violation the state goes to IDLE and no write occurs.
- Simultaneous count edge and write commit in the same cycle: the write uses the pre-increment addr.
- n_ce high forces IDLE on the next cycle from any state.

Optional Feature:
- Macro: SRAM_RESP_PARITY_EN.
- Defined:
  - The array stores DW+1 bits; the extra bit is the even parity of the hold register at commit.
  - On each data_out load, parity is recomputed. A mismatch sets a sticky err bit, which is OR-ed into err.
  - An additional port par_err (output, 1) exposes the parity flag alone.
- Undefined: array is DW bits wide; there is no par_err port; no parity logic is generated.

Decomposition:
- Shared package sram_pkg:
  - State enum (IDLE, WRITE, READ_WAIT, DRIVE) with a 2-bit encoding.
  - Default DW/AW/READ_LAT constants.
  - A parity function.
- One natural sub-module, sram_edge_sync: registers the six control inputs and emits rise/fall pulses.
- The array stays inline as a register array indexed by addr.

Test Plan:
- Reset mid-burst:
  - Stimulus: assert reset=0 while in DRIVE with addr=5.
  - Required: addr=0, data_valid=0, err=0 immediately, without waiting for a clock edge.
  - Required: after release, a read of addr 5 returns the prior contents.
- Write/read-back:
  - Stimulus: latch 0xA5; de=1; pulse n_we low for 2 cycles at addr=3.
  - Then: n_oe low at addr=3.
  - Required: data_valid rises 2 cycles after the registered n_oe fall, with data_out=0xA5.
- Write gated:
  - Stimulus: same as the write/read-back case but with de=0.
  - Required: addr 3 retains its old value 0x00; err=0.
- Burst wrap:
  - Stimulus: AW=4; write 16 words 0x10..0x1F via count pulses; read burst starting at addr=15; one count pulse.
  - Required: data_out goes 0x1F then 0x10; addr goes 15 then 0.
- Violation:
  - Stimulus: n_ce=0, n_oe=0, n_we=0 in the same cycle.
  - Required: err=1 within 2 cycles; no array change; state returns to IDLE.
  - Required: err stays 1 until reset.
- Parity (SRAM_RESP_PARITY_EN defined):
  - Stimulus: force-flip a stored bit of the word at addr=2, then read addr=2.
  - Required: par_err=1 and err=1 in the cycle data_valid rises.
